vend_coin_feeder: RTL and testbench

//  Payer-side driver for the vending coin interface. It accepts a purse budget and an item quantity.
//  It emits coin codes on D_in[1:0] toward the vending FSM (price PRICE units) and tracks D_out_moore vend pulses.
//  It reports items vended, change left over, and a completion/error status.
//  It sits between the test/host controller and the vending FSM; it is also used as a bench stimulus source.

---
 rtl/vend_coin_feeder_if.sv | 37 +++
 rtl/vend_coin_feeder.sv | 186 ++++++++++++++++++
 tb/tb_vend_coin_feeder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vend_coin_feeder_if.sv
// vend_coin_feeder_if: host and vending-FSM signals of the coin feeder.
// Defining VEND_COIN_STATS_EN adds the coins_total/to_count statistics outputs.
interface vend_coin_feeder_if #(
    parameter int BW = 8
);
    logic          start;
    logic [BW-1:0] budget;
    logic [2:0]    qty;
    logic [1:0]    D_in;
    logic          D_out_moore;
    logic          busy;
    logic          done;
    logic          err;
    logic [BW-1:0] change;
    logic [2:0]    vended;
`ifdef VEND_COIN_STATS_EN
    logic [15:0]   coins_total;
    logic [7:0]    to_count;
    modport slave (
        input  start, budget, qty, D_out_moore,
        output D_in, busy, done, err, change, vended, coins_total, to_count
    );
    modport master (
        output start, budget, qty, D_out_moore,
        input  D_in, busy, done, err, change, vended, coins_total, to_count
    );
`else
    modport slave (
        input  start, budget, qty, D_out_moore,
        output D_in, busy, done, err, change, vended
    );
    modport master (
        output start, budget, qty, D_out_moore,
        input  D_in, busy, done, err, change, vended
    );
`endif
endinterface

// File: rtl/vend_coin_feeder.sv
// vend_coin_feeder: pays for qty items with coins on D_in and counts vend pulses.
// Defining VEND_COIN_STATS_EN adds saturating coin and timeout counters.
module vend_coin_feeder #(
    parameter int BW      = 8,
    parameter int PRICE   = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input logic               Clk,
    input logic               Reset,
    vend_coin_feeder_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_COIN  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [1:0]    d_in_q, d_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [BW-1:0] change_q, change_d;
    logic [2:0]    vended_q, vended_d;
    logic [BW-1:0] bal_q, bal_d;
    logic [2:0]    qty_q, qty_d;
    logic [3:0]    paid_q, paid_d;
    logic [2:0]    gap_q, gap_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          coin_go;
    logic          tmo_hit;
    logic [3:0]    rem;
    logic [1:0]    coin_v;

    // Coin for the upcoming COIN cycle; D_in, paid and bal all update on entry to COIN.
    assign rem    = 4'(PRICE) - paid_q;
    assign coin_v = (rem > 4'd3) ? 2'd3 : rem[1:0];

    always_comb begin
        state_d  = state_q;
        d_in_d   = 2'b00;
        done_d   = 1'b0;
        err_d    = err_q;
        change_d = change_q;
        vended_d = vended_q;
        bal_d    = bal_q;
        qty_d    = qty_q;
        paid_d   = paid_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        coin_go  = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bal_d    = bus.budget;
                    qty_d    = bus.qty;
                    paid_d   = 4'd0;
                    vended_d = 3'd0;
                    err_d    = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (vended_q == qty_q) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (bal_q < BW'(PRICE)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    coin_go = 1'b1;
                    state_d = S_COIN;
                end
            end
            S_COIN: begin
                if (paid_q == 4'(PRICE)) begin
                    tmo_d   = 8'd0;
                    state_d = S_WAIT;
                end else if (GAP > 0) begin
                    gap_d   = 3'(GAP - 1);
                    state_d = S_GAP;
                end else begin
                    coin_go = 1'b1;
                    state_d = S_COIN;
                end
            end
            S_GAP: begin
                if (gap_q == 3'd0) begin
                    coin_go = 1'b1;
                    state_d = S_COIN;
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            S_WAIT: begin
                if (bus.D_out_moore) begin
                    vended_d = vended_q + 3'd1;
                    paid_d   = 4'd0;
                    state_d  = S_CHECK;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    tmo_hit = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (coin_go) begin
            d_in_d = coin_v;
            paid_d = paid_q + {2'b00, coin_v};
            bal_d  = bal_q - BW'(coin_v);
        end
        if (state_d == S_DONE) begin
            done_d   = 1'b1;
            change_d = bal_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            d_in_q   <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            change_q <= '0;
            vended_q <= 3'd0;
            bal_q    <= '0;
            qty_q    <= 3'd0;
            paid_q   <= 4'd0;
            gap_q    <= 3'd0;
            tmo_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            d_in_q   <= d_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            change_q <= change_d;
            vended_q <= vended_d;
            bal_q    <= bal_d;
            qty_q    <= qty_d;
            paid_q   <= paid_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.D_in   = d_in_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.change = change_q;
    assign bus.vended = vended_q;

`ifdef VEND_COIN_STATS_EN
    logic [15:0] coins_q;
    logic [7:0]  to_q;

    // Counted on the edge that loads a nonzero D_in, so the count includes the visible coin.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            coins_q <= 16'd0;
            to_q    <= 8'd0;
        end else begin
            if (d_in_d != 2'b00 && coins_q != 16'hFFFF)
                coins_q <= coins_q + 16'd1;
            if (tmo_hit && to_q != 8'hFF)
                to_q <= to_q + 8'd1;
        end
    end

    assign bus.coins_total = coins_q;
    assign bus.to_count    = to_q;
`else
    logic unused_tmo_hit;
    assign unused_tmo_hit = tmo_hit;
`endif
endmodule

// File: tb/tb_vend_coin_feeder.sv
// tb_vend_coin_feeder: scoreboard bench for vend_coin_feeder with a behavioural vending FSM.
module tb_vend_coin_feeder;
    localparam int BW = 8, PRICE = 4, GAP = 1, TIMEOUT = 8;

    typedef struct {
        logic       err;
        logic [2:0] vended;
        logic [7:0] change;
        int         lat;
        int         paid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vm_en = 1'b1;
    logic force_vend = 1'b0;
    logic vend_q;
    int   acc;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vend_coin_feeder_if #(.BW(BW)) bus();

    vend_coin_feeder #(.BW(BW), .PRICE(PRICE), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .Clk(clk),
        .Reset(rst),
        .bus(bus)
    );

    // Vending FSM: accumulates coins and raises a registered one-cycle vend once PRICE is reached.
    always @(posedge clk) begin
        if (rst) begin
            acc    <= 0;
            vend_q <= 1'b0;
        end else if (acc + int'(bus.D_in) >= PRICE) begin
            acc    <= acc + int'(bus.D_in) - PRICE;
            vend_q <= 1'b1;
        end else begin
            acc    <= acc + int'(bus.D_in);
            vend_q <= 1'b0;
        end
    end

    assign bus.D_out_moore = (vm_en & vend_q) | force_vend;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [2:0] q);
        tick;
        bus.budget = b;
        bus.qty    = q;
        bus.start  = 1'b1;
        tick;
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit got, output int paid);
        lat  = 0;
        got  = 1'b0;
        paid = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick;
            lat++;
            paid += int'(bus.D_in);
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++; if (bus.D_in !== 2'b00) begin n_bad++; $display("FAIL rst_din: got %b want 00", bus.D_in); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.change !== 8'd0) begin n_bad++; $display("FAIL rst_change: got %0d want 0", bus.change); end
        n_cmp++; if (bus.vended !== 3'd0) begin n_bad++; $display("FAIL rst_vended: got %0d want 0", bus.vended); end
        rst = 1'b0;
    endtask

    task automatic test_qty0;
        int lat, paid; bit got; exp_t e;
        sb.push_back('{err: 1'b0, vended: 3'd0, change: 8'd9, lat: 1, paid: 0});
        pulse_start(8'd9, 3'd0);
        wait_done(lat, got, paid);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL q0_done: got no done want done"); end
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL q0_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL q0_err: got %b want %b", bus.err, e.err); end
        n_cmp++; if (bus.change !== e.change) begin n_bad++; $display("FAIL q0_change: got %0d want %0d", bus.change, e.change); end
        n_cmp++; if (paid != e.paid) begin n_bad++; $display("FAIL q0_paid: got %0d want %0d", paid, e.paid); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL q0_busy_done: got %b want 1", bus.busy); end
        tick;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL q0_busy_after: got %b want 0", bus.busy); end
        n_cmp++; if (bus.change !== e.change) begin n_bad++; $display("FAIL q0_change_hold: got %0d want %0d", bus.change, e.change); end
    endtask

    task automatic test_nominal;
        int lat, lat2, paid; bit got; exp_t e;
        logic [1:0] dq[$];
        logic [1:0] w;
        dq = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
        sb.push_back('{err: 1'b0, vended: 3'd2, change: 8'd2, lat: 11, paid: 8});
        pulse_start(8'd10, 3'd2);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy: got %b want 1", bus.busy); end
        lat  = 0;
        paid = 0;
        while (dq.size() > 0) begin
            tick;
            lat++;
            paid += int'(bus.D_in);
            w = dq.pop_front();
            n_cmp++; if (bus.D_in !== w) begin n_bad++; $display("FAIL nom_din%0d: got %b want %b", lat, bus.D_in, w); end
        end
        wait_done(lat2, got, paid);
        lat += lat2;
        paid = 8;
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL nom_done: got no done want done"); end
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL nom_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL nom_err: got %b want %b", bus.err, e.err); end
        n_cmp++; if (bus.vended !== e.vended) begin n_bad++; $display("FAIL nom_vended: got %0d want %0d", bus.vended, e.vended); end
        n_cmp++; if (bus.change !== e.change) begin n_bad++; $display("FAIL nom_change: got %0d want %0d", bus.change, e.change); end
    endtask

    task automatic test_short_funds;
        int lat, paid; bit got; exp_t e;
        sb.push_back('{err: 1'b1, vended: 3'd1, change: 8'd2, lat: 6, paid: 4});
        pulse_start(8'd6, 3'd3);
        wait_done(lat, got, paid);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL sf_done: got no done want done"); end
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL sf_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL sf_err: got %b want %b", bus.err, e.err); end
        n_cmp++; if (bus.vended !== e.vended) begin n_bad++; $display("FAIL sf_vended: got %0d want %0d", bus.vended, e.vended); end
        n_cmp++; if (bus.change !== e.change) begin n_bad++; $display("FAIL sf_change: got %0d want %0d", bus.change, e.change); end
        n_cmp++; if (paid != e.paid) begin n_bad++; $display("FAIL sf_paid: got %0d want %0d", paid, e.paid); end
    endtask

    task automatic test_timeout;
        int lat, paid; bit got; exp_t e;
        vm_en = 1'b0;
        sb.push_back('{err: 1'b1, vended: 3'd0, change: 8'd0, lat: 4 + TIMEOUT, paid: 4});
        pulse_start(8'd4, 3'd1);
        wait_done(lat, got, paid);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL to_done: got no done want done"); end
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL to_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL to_err: got %b want %b", bus.err, e.err); end
        n_cmp++; if (bus.vended !== e.vended) begin n_bad++; $display("FAIL to_vended: got %0d want %0d", bus.vended, e.vended); end
        n_cmp++; if (bus.change !== e.change) begin n_bad++; $display("FAIL to_change: got %0d want %0d", bus.change, e.change); end
        n_cmp++; if (paid != e.paid) begin n_bad++; $display("FAIL to_paid: got %0d want %0d", paid, e.paid); end
        tick;
        vm_en = 1'b1;
    endtask

    task automatic test_reset_in_gap;
        int seen;
        pulse_start(8'd10, 3'd2);
        tick;
        tick;
        rst = 1'b1;
        tick;
        n_cmp++; if (bus.D_in !== 2'b00) begin n_bad++; $display("FAIL rg_din: got %b want 00", bus.D_in); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rg_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.vended !== 3'd0) begin n_bad++; $display("FAIL rg_vended: got %0d want 0", bus.vended); end
        rst  = 1'b0;
        seen = int'(bus.done);
        for (int i = 0; i < 6; i++) begin
            tick;
            seen += int'(bus.done);
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rg_no_done: got %0d pulses want 0", seen); end
        test_nominal;
    endtask

    task automatic test_ignore;
        int lat, lat2, paid; bit got; exp_t e;
        sb.push_back('{err: 1'b0, vended: 3'd2, change: 8'd2, lat: 11, paid: 0});
        pulse_start(8'd10, 3'd2);
        tick;
        force_vend = 1'b1;
        tick;
        force_vend  = 1'b0;
        bus.budget  = 8'd50;
        bus.qty     = 3'd5;
        bus.start   = 1'b1;
        tick;
        bus.start   = 1'b0;
        n_cmp++; if (bus.vended !== 3'd0) begin n_bad++; $display("FAIL ig_vended_mid: got %0d want 0", bus.vended); end
        wait_done(lat2, got, paid);
        lat = 3 + lat2;
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL ig_done: got no done want done"); end
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL ig_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL ig_err: got %b want %b", bus.err, e.err); end
        n_cmp++; if (bus.vended !== e.vended) begin n_bad++; $display("FAIL ig_vended: got %0d want %0d", bus.vended, e.vended); end
        n_cmp++; if (bus.change !== e.change) begin n_bad++; $display("FAIL ig_change: got %0d want %0d", bus.change, e.change); end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.budget = 8'd0;
        bus.qty    = 3'd0;
        test_reset;
        test_qty0;
        test_nominal;
        test_short_funds;
        test_timeout;
        test_reset_in_gap;
        test_ignore;
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_left: got %0d entries want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
